// File: rtl/koblitz_embed.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// koblitz_embed
//   Koblitz message-to-point embedding. Starting from x = m*KOBLITZ, the block
//   walks the candidates x = m*KOBLITZ + j for j = 0..KOBLITZ-1. For each one
//   it forms rhs = x^3 + A*x + B mod P and runs an Euler test,
//   rhs^((P-1)/2) == 1. On the first quadratic residue it takes the square
//   root y = rhs^((P+1)/4) and returns (x, y). A message is recovered with
//   m = floor(x / KOBLITZ).
//   All arithmetic uses a single bit-serial modular multiplier, so the
//   latency depends on the data.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   msg_valid  in   message present on msg
//   msg        in   message integer m
//   msg_ready  out  block idle; accepts when msg_valid && msg_ready
//   pt_valid   out  result present, held until pt_ready
//   pt_ready   in   consumer takes the result when pt_valid && pt_ready
//   pt_x       out  embedded point x (0 on fail)
//   pt_y       out  embedded point y (0 on fail)
//   pt_fail    out  no residue among the candidates, or candidate range >= P
//
// Build option
//   ECEG_CANONICAL_Y_EN : when defined, an odd y is replaced by P-y, so the
//                         reported y is always even (one extra cycle).
// ---------------------------------------------------------------------------
module koblitz_embed #(
   parameter int WIDTH   = 16,
   parameter int P       = 23,
   parameter int A       = 1,
   parameter int B       = 1,
   parameter int KOBLITZ = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             msg_valid,
   input  logic [WIDTH-1:0] msg,
   output logic             msg_ready,
   output logic             pt_valid,
   input  logic             pt_ready,
   output logic [WIDTH-1:0] pt_x,
   output logic [WIDTH-1:0] pt_y,
   output logic             pt_fail
);

   localparam int W2 = 2 * WIDTH;
   localparam int JW = (KOBLITZ > 1) ? $clog2(KOBLITZ + 1) : 1;
   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] PW      = WIDTH'(P);
   localparam logic [WIDTH-1:0] AW      = WIDTH'(A);
   localparam logic [WIDTH-1:0] BW      = WIDTH'(B);
   localparam logic [WIDTH-1:0] E_EULER = WIDTH'((P - 1) / 2);
   localparam logic [WIDTH-1:0] E_SQRT  = WIDTH'((P + 1) / 4);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_RANGE, S_RHS, S_EULER, S_NEXT, S_SQRT, S_CANON, S_DONE
   } state_t;

   // (a + b) mod P for a, b < P: the sum is below 2P, so one subtract is enough.
   function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, PW}) s = s - {1'b0, PW};
      return s[WIDTH-1:0];
   endfunction

   // One MSB-first interleaved step: acc = 2*acc (+ a if the multiplier bit is set), mod P.
   function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] a,
                                                input logic             mbit);
      logic [WIDTH:0] t;
      t = {acc, 1'b0};
      if (t >= {1'b0, PW}) t = t - {1'b0, PW};
      return add_mod(t[WIDTH-1:0], mbit ? a : '0);
   endfunction

   state_t           state, nxt;
   logic [WIDTH-1:0] m_r, x_r, t_r, u_r, rhs_r, r_r;
   logic [JW-1:0]    j_r;
   logic [1:0]       ph_r;          // rhs sub-step: x*x, x^2*x, A*x, combine
   logic [KW-1:0]    kb_r;          // exponent bit under processing
   logic             sub_r;         // 0: squaring, 1: multiply by base
   logic             issued_r;      // a multiply is in flight for this step
   logic [WIDTH-1:0] res_x, res_y;
   logic             res_fail;

   logic [WIDTH-1:0] mm_a, mm_b, mm_acc;
   logic [CW-1:0]    mm_cnt;
   logic             mm_done;
   logic             mm_go;
   logic [WIDTH-1:0] op_a, op_b;

   logic [W2-1:0]    mk, lim;
   logic             range_bad, ebit, exp_last, accept;
   logic [WIDTH-1:0] exp_e;

   assign accept    = msg_valid && (state == S_IDLE);
   assign mk        = W2'(m_r) * W2'(KOBLITZ);
   assign lim       = mk + W2'(KOBLITZ - 1);
   assign range_bad = (lim >= W2'(P));
   assign exp_e     = (state == S_SQRT) ? E_SQRT : E_EULER;
   assign ebit      = exp_e[kb_r];
   // The final multiply of an exponentiation: bit 0 with no pending base multiply.
   assign exp_last  = mm_done && (kb_r == '0) && (sub_r || !ebit);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      unique case (state)
         S_INIT:  nxt = S_IDLE;
         S_IDLE:  if (msg_valid) nxt = S_RANGE;
         S_RANGE: nxt = range_bad ? S_DONE : S_RHS;
         S_RHS:   if (ph_r == 2'd3) nxt = S_EULER;
         S_EULER: begin
            if (rhs_r == '0)   nxt = S_DONE;
            else if (exp_last) nxt = (mm_acc == WIDTH'(1)) ? S_SQRT : S_NEXT;
         end
         S_NEXT:  nxt = (j_r == JW'(KOBLITZ - 1)) ? S_DONE : S_RHS;
         S_SQRT: begin
            if (exp_last)
`ifdef ECEG_CANONICAL_Y_EN
               nxt = S_CANON;
`else
               nxt = S_DONE;
`endif
         end
         S_CANON: nxt = S_DONE;
         S_DONE:  if (pt_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Output / multiplier-issue logic
   always_comb begin
      msg_ready = (state == S_IDLE);
      pt_valid  = (state == S_DONE);
      mm_go     = 1'b0;
      op_a      = '0;
      op_b      = '0;
      unique case (state)
         S_RHS: begin
            mm_go = !issued_r && (ph_r != 2'd3);
            op_b  = x_r;
            unique case (ph_r)
               2'd0:    op_a = x_r;
               2'd1:    op_a = t_r;
               default: op_a = AW;
            endcase
         end
         S_EULER, S_SQRT: begin
            mm_go = !issued_r && (rhs_r != '0);
            op_a  = r_r;
            op_b  = sub_r ? rhs_r : r_r;
         end
         default: ;
      endcase
   end

   assign pt_x    = res_x;
   assign pt_y    = res_y;
   assign pt_fail = res_fail;

   // Control, sequencing and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_x    <= '0;
         res_y    <= '0;
         res_fail <= 1'b0;
         issued_r <= 1'b0;
         ph_r     <= '0;
         kb_r     <= '0;
         sub_r    <= 1'b0;
         j_r      <= '0;
         mm_cnt   <= '0;
         mm_done  <= 1'b0;
      end else begin
         // Multiplier: one load cycle then WIDTH shift-add steps.
         if (mm_go) begin
            mm_cnt  <= CW'(WIDTH);
            mm_done <= 1'b0;
         end else if (mm_cnt != '0) begin
            mm_cnt  <= mm_cnt - 1'b1;
            mm_done <= (mm_cnt == CW'(1));
         end else begin
            mm_done <= 1'b0;
         end

         if (mm_go)        issued_r <= 1'b1;
         else if (mm_done) issued_r <= 1'b0;

         unique case (state)
            S_IDLE: if (accept) begin
               res_x    <= '0;
               res_y    <= '0;
               res_fail <= 1'b0;
               j_r      <= '0;
               ph_r     <= '0;
            end
            S_RANGE: if (range_bad) res_fail <= 1'b1;
            S_RHS: begin
               if (ph_r == 2'd3) begin
                  ph_r  <= '0;
                  kb_r  <= KW'(WIDTH - 1);
                  sub_r <= 1'b0;
               end else if (mm_done) begin
                  ph_r <= ph_r + 2'd1;
               end
            end
            S_EULER, S_SQRT: begin
               if (state == S_EULER && rhs_r == '0) begin
                  res_x <= x_r;
                  res_y <= '0;
               end else if (exp_last) begin
                  kb_r  <= KW'(WIDTH - 1);
                  sub_r <= 1'b0;
                  if (state == S_SQRT) begin
                     res_x <= x_r;
                     res_y <= mm_acc;
                  end
               end else if (mm_done) begin
                  if (!sub_r && ebit) begin
                     sub_r <= 1'b1;
                  end else begin
                     sub_r <= 1'b0;
                     kb_r  <= kb_r - 1'b1;
                  end
               end
            end
            S_NEXT: begin
               j_r  <= j_r + 1'b1;
               ph_r <= '0;
               if (j_r == JW'(KOBLITZ - 1)) res_fail <= 1'b1;
            end
`ifdef ECEG_CANONICAL_Y_EN
            S_CANON: if (res_y[0]) res_y <= PW - res_y;
`endif
            default: ;
         endcase
      end
   end

   // Datapath registers (no reset: only read after being written)
   always_ff @(posedge clk) begin
      if (mm_go) begin
         mm_a   <= op_a;
         mm_b   <= op_b;
         mm_acc <= '0;
      end else if (mm_cnt != '0) begin
         mm_acc <= mm_step(mm_acc, mm_a, mm_b[WIDTH-1]);
         mm_b   <= {mm_b[WIDTH-2:0], 1'b0};
      end

      if (accept)            m_r <= msg;
      if (state == S_RANGE)  x_r <= mk[WIDTH-1:0];
      if (state == S_NEXT)   x_r <= x_r + 1'b1;

      if (state == S_RHS) begin
         if (ph_r == 2'd3) begin
            rhs_r <= add_mod(add_mod(t_r, u_r), BW);
            r_r   <= WIDTH'(1);
         end else if (mm_done) begin
            if (ph_r == 2'd2) u_r <= mm_acc;
            else              t_r <= mm_acc;
         end
      end

      // Running exponent value; restarts at 1 so SQRT begins cleanly after EULER.
      if ((state == S_EULER || state == S_SQRT) && mm_done)
         r_r <= exp_last ? WIDTH'(1) : mm_acc;
   end

endmodule
